// File: rtl/inv_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : inv_share_arbiter
// Description : Round-robin controller that shares one W-bit inverter among
//               NREQ requesters. It arbitrates, latches the winning operand,
//               drives the shared inverter, then returns the captured result
//               tagged with the requester ID. It also raises a sticky flag
//               whenever the inverter output differs from ~operand.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   1       system clock, rising edge
//   rst        in   1       synchronous reset, active-high
//   req        in   NREQ    per-requester request (bit k = requester k)
//   req_data   in   NREQ*W  operands, requester k at [k*W +: W]
//   gnt        out  NREQ    one-hot grant/ack pulse, registered
//   inv_in     out  W       operand presented to the shared inverter
//   inv_out    in   W       combinational result from the shared inverter
//   resp_valid out  1       one-cycle pulse: result available
//   resp_id    out  IDW     requester index of the current result
//   resp_data  out  W       captured inverter result
//   busy       out  1       operation in flight (state != IDLE)
//   mismatch   out  1       sticky: inverter result != ~operand
// ============================================================================
module inv_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    output logic [W-1:0]      inv_in,
    input  logic [W-1:0]      inv_out,
    output logic              resp_valid,
    output logic [IDW-1:0]    resp_id,
    output logic [W-1:0]      resp_data,
    output logic              busy,
    output logic              mismatch
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    localparam logic [IDW-1:0] C_RR_LAST_RST = IDW'(NREQ - 1);

    state_t            r_state_q,      w_state_d;
    logic [NREQ-1:0]   r_gnt_q,        w_gnt_d;
    logic [W-1:0]      r_dreg_q,       w_dreg_d;
    logic [IDW-1:0]    r_id_q,         w_id_d;
    logic [IDW-1:0]    r_rr_last_q,    w_rr_last_d;
    logic              r_resp_valid_q, w_resp_valid_d;
    logic [IDW-1:0]    r_resp_id_q,    w_resp_id_d;
    logic [W-1:0]      r_resp_data_q,  w_resp_data_d;
    logic              r_mismatch_q,   w_mismatch_d;

    // Arbitration helpers
    logic              w_any;       // any request present
    logic              w_hi_any;    // any request above rr_last
    logic [IDW-1:0]    w_lo;        // lowest requesting index overall
    logic [IDW-1:0]    w_hi;        // lowest requesting index above rr_last
    logic [IDW-1:0]    w_win;
    logic [W-1:0]      w_win_data;

    // Round-robin pick: the lowest requester above rr_last wins; if none is
    // above it the search wraps and the lowest requester overall wins.
    // Scanning downward lets the last assignment be the lowest index.
    always_comb begin
        w_any      = 1'b0;
        w_hi_any   = 1'b0;
        w_lo       = '0;
        w_hi       = '0;
        w_win_data = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                w_any = 1'b1;
                w_lo  = IDW'(k);
                if (IDW'(k) > r_rr_last_q) begin
                    w_hi_any = 1'b1;
                    w_hi     = IDW'(k);
                end
            end
        end
        w_win = w_hi_any ? w_hi : w_lo;
        for (int k = 0; k < NREQ; k++) begin
            if (IDW'(k) == w_win) begin
                w_win_data = req_data[k*W +: W];
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d      = r_state_q;
        w_gnt_d        = r_gnt_q;
        w_dreg_d       = r_dreg_q;
        w_id_d         = r_id_q;
        w_rr_last_d    = r_rr_last_q;
        w_resp_valid_d = 1'b0;
        w_resp_id_d    = r_resp_id_q;
        w_resp_data_d  = r_resp_data_q;
        w_mismatch_d   = r_mismatch_q;

        case (r_state_q)
            ST_IDLE: begin
                if (w_any) begin
                    w_gnt_d     = NREQ'(1) << w_win;
                    w_dreg_d    = w_win_data;
                    w_id_d      = w_win;
                    w_rr_last_d = w_win;
                    w_state_d   = ST_GRANT;
                end
            end
            ST_GRANT: begin
                w_gnt_d   = '0;
                w_state_d = ST_EXEC;
            end
            ST_EXEC: begin
                w_resp_data_d  = inv_out;
                w_resp_id_d    = r_id_q;
                w_resp_valid_d = 1'b1;
                if (inv_out != ~r_dreg_q) begin
                    w_mismatch_d = 1'b1;
                end
                w_state_d = ST_IDLE;
            end
            default: begin
                w_gnt_d   = '0;
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= ST_IDLE;
            r_gnt_q        <= '0;
            r_dreg_q       <= '0;
            r_id_q         <= '0;
            r_rr_last_q    <= C_RR_LAST_RST;
            r_resp_valid_q <= 1'b0;
            r_resp_id_q    <= '0;
            r_resp_data_q  <= '0;
            r_mismatch_q   <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_gnt_q        <= w_gnt_d;
            r_dreg_q       <= w_dreg_d;
            r_id_q         <= w_id_d;
            r_rr_last_q    <= w_rr_last_d;
            r_resp_valid_q <= w_resp_valid_d;
            r_resp_id_q    <= w_resp_id_d;
            r_resp_data_q  <= w_resp_data_d;
            r_mismatch_q   <= w_mismatch_d;
        end
    end

    assign gnt        = r_gnt_q;
    assign inv_in     = r_dreg_q;
    assign resp_valid = r_resp_valid_q;
    assign resp_id    = r_resp_id_q;
    assign resp_data  = r_resp_data_q;
    assign busy       = (r_state_q != ST_IDLE);
    assign mismatch   = r_mismatch_q;

endmodule
`default_nettype wire

// File: tb/tb_inv_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_inv_share_arbiter
// Description : Scoreboard bench for inv_share_arbiter. Stimulus pushes the
//               expected grants and responses; a negedge monitor pops and
//               compares whenever gnt or resp_valid is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic [NREQ-1:0]   req      = '0;
    logic [NREQ-1:0]   keep     = '0;   // requesters that hold req through gnt
    logic [NREQ*W-1:0] req_data = '0;
    logic              fault    = 1'b0; // inverter model becomes pass-through
    logic [NREQ-1:0]   gnt;
    logic [W-1:0]      inv_in;
    logic [W-1:0]      inv_out;
    logic              resp_valid;
    logic [IDW-1:0]    resp_id;
    logic [W-1:0]      resp_data;
    logic              busy;
    logic              mismatch;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   data;
        logic           mm;
    } resp_t;

    resp_t           exp_resp[$];
    logic [NREQ-1:0] exp_gnt[$];

    always #5 clk = ~clk;

    // Shared inverter model
    assign inv_out = fault ? inv_in : ~inv_in;

    inv_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .inv_in     (inv_in),
        .inv_out    (inv_out),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .busy       (busy),
        .mismatch   (mismatch)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Advance one cycle; requesters not in keep drop req once granted.
    task automatic step();
        @(posedge clk);
        #1;
        req = req & ~(gnt & ~keep);
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic set_data(input int k, input logic [W-1:0] d);
        req_data[k*W +: W] = d;
    endtask

    task automatic push(input logic [NREQ-1:0] g, input logic [IDW-1:0] id,
                        input logic [W-1:0] d, input logic mm);
        resp_t r;
        r.id   = id;
        r.data = d;
        r.mm   = mm;
        exp_gnt.push_back(g);
        exp_resp.push_back(r);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        steps(2);
        rst = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_rst_gnt"},       32'(gnt),        32'h0);
        check({tag, "_rst_inv_in"},    32'(inv_in),     32'h0);
        check({tag, "_rst_valid"},     32'(resp_valid), 32'h0);
        check({tag, "_rst_resp_id"},   32'(resp_id),    32'h0);
        check({tag, "_rst_resp_data"}, 32'(resp_data),  32'h0);
        check({tag, "_rst_busy"},      32'(busy),       32'h0);
        check({tag, "_rst_mismatch"},  32'(mismatch),   32'h0);
    endtask

    // Monitor: compares every presented grant and response with the queues.
    initial begin
        @(negedge rst);
        forever begin
            @(negedge clk);
            if (gnt != '0) begin
                if (exp_gnt.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL gnt_unexpected: got %0h want none", gnt);
                end else begin
                    check("gnt", 32'(gnt), 32'(exp_gnt.pop_front()));
                end
            end
            if (resp_valid) begin
                if (exp_resp.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL resp_unexpected: got id=%0h data=%0h want none", resp_id, resp_data);
                end else begin
                    // packed as {id, data, mismatch}
                    check("resp", 32'({resp_id, resp_data, mismatch}), 32'(exp_resp.pop_front()));
                end
            end
        end
    end

    initial begin
        steps(3);
        rst = 1'b0;
        reset_checks("init");

        // Single request, correct inverter
        set_data(0, 8'hA5);
        req = 4'b0001;
        push(4'b0001, 2'd0, 8'h5A, 1'b0);
        step();
        check("t1_gnt_c1", 32'(gnt), 32'h1);
        step();
        check("t1_inv_in_c2", 32'(inv_in), 32'hA5);
        check("t1_busy_c2", 32'(busy), 32'h1);
        step();
        check("t1_valid_c3", 32'(resp_valid), 32'h1);
        steps(2);

        // All four request from reset: grants 0,1,2,3
        do_reset();
        set_data(0, 8'h10);
        set_data(1, 8'h11);
        set_data(2, 8'h12);
        set_data(3, 8'h13);
        req = 4'b1111;
        push(4'b0001, 2'd0, 8'hEF, 1'b0);
        push(4'b0010, 2'd1, 8'hEE, 1'b0);
        push(4'b0100, 2'd2, 8'hED, 1'b0);
        push(4'b1000, 2'd3, 8'hEC, 1'b0);
        steps(13);

        // Fairness: 0 and 2 re-request continuously
        set_data(0, 8'h01);
        set_data(2, 8'h02);
        keep = 4'b0101;
        req  = 4'b0101;
        push(4'b0001, 2'd0, 8'hFE, 1'b0);
        push(4'b0100, 2'd2, 8'hFD, 1'b0);
        push(4'b0001, 2'd0, 8'hFE, 1'b0);
        push(4'b0100, 2'd2, 8'hFD, 1'b0);
        steps(10);
        keep = '0;
        req  = '0;
        steps(4);

        // Faulty datapath, then sticky mismatch through a good operation
        fault = 1'b1;
        set_data(0, 8'h3C);
        req = 4'b0001;
        push(4'b0001, 2'd0, 8'h3C, 1'b1);
        steps(4);
        fault = 1'b0;
        set_data(1, 8'h55);
        req = 4'b0010;
        push(4'b0010, 2'd1, 8'hAA, 1'b1);
        steps(4);
        check("t4_sticky", 32'(mismatch), 32'h1);
        do_reset();
        reset_checks("t4");

        // Reset during EXEC aborts the operation
        set_data(0, 8'h77);
        req = 4'b0001;
        exp_gnt.push_back(4'b0001);
        steps(2);
        check("t5_busy_exec", 32'(busy), 32'h1);
        check("t5_inv_in_exec", 32'(inv_in), 32'h77);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_abort_gnt", 32'(gnt), 32'h0);
        check("t5_abort_busy", 32'(busy), 32'h0);
        check("t5_abort_inv_in", 32'(inv_in), 32'h0);
        check("t5_abort_valid", 32'(resp_valid), 32'h0);
        // rr_last must be back at NREQ-1, so requester 0 wins over 1
        set_data(0, 8'h0F);
        set_data(1, 8'hF0);
        req = 4'b0011;
        push(4'b0001, 2'd0, 8'hF0, 1'b0);
        push(4'b0010, 2'd1, 8'h0F, 1'b0);
        steps(8);

        // Idle stability
        req = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("t6_idle", 32'({gnt, resp_valid, busy}), 32'h0);
        end
        steps(2);

        check("sb_gnt_drained", 32'(exp_gnt.size()), 32'h0);
        check("sb_resp_drained", 32'(exp_resp.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inv_share_arbiter.md
Name: inv_share_arbiter

Overview:
Round-robin controller that shares one W-bit inverter datapath among NREQ requesters. It arbitrates requests, latches the winner's operand, and drives the shared inverter. It then captures the inverted result and returns it tagged with the requester ID. It also checks the inverter output against the expected complement and flags any mismatch. It sits between requester logic and the single instantiated inverter block.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 8, operand/result width in bits
IDW, 2, requester-ID width; must satisfy 2**IDW >= NREQ

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
req  input  NREQ  per-requester request; bit k belongs to requester k
req_data  input  NREQ*W  operands; requester k uses bits [k*W +: W]
gnt  output  NREQ  one-hot grant/ack pulse, registered
inv_in  output  W  operand driven to the shared inverter
inv_out  input  W  result from the shared inverter (combinational, same cycle)
resp_valid  output  1  one-cycle pulse: result available
resp_id  output  IDW  requester index of the current result
resp_data  output  W  captured inverter result
busy  output  1  high while an operation is in flight (state != IDLE)
mismatch  output  1  sticky error: inverter result != ~operand

Behaviour:
- One clock domain (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, gnt=0, inv_in=0, resp_valid=0, resp_id=0, resp_data=0, busy=0, mismatch=0, rr_last=NREQ-1.
- inv_in is driven from the operand register dreg at all times, so it equals 0 after reset.
- State machine states: IDLE, GRANT, EXEC.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick winner k: the first set bit of req, searching from rr_last+1 upward, mod NREQ.
  - At that edge: gnt[k]<=1, dreg<=req_data[k], id<=k, rr_last<=k, state<=GRANT.
- GRANT (one cycle): gnt is high.
  - Requester k must drop req[k] at the next edge; gnt serves as the ack.
  - Next edge: gnt<=0, state<=EXEC.
- EXEC (one cycle): inv_in=dreg and inv_out must be valid by the end of the cycle.
  - Next edge: resp_data<=inv_out, resp_id<=id, resp_valid<=1, state<=IDLE.
  - At the same edge, if inv_out != ~dreg then mismatch<=1.
- resp_valid is high for exactly the one cycle after EXEC. That cycle is an IDLE cycle, so a new arbitration may occur in it.
- Latency: req sampled at edge 0 -> gnt high in cycle 1 -> resp_valid high in cycle 3.
- Throughput: one operation per 3 cycles under continuous requests.
- req and req_data of non-granted requesters are ignored. Requests arriving while busy wait; no request is lost if held.
- A requester that keeps req high through GRANT is treated as a new request. Round-robin still gives others priority.
- mismatch is cleared only by rst.
- Reset mid-operation: rst in GRANT or EXEC aborts the operation. No resp_valid is produced, the state returns to IDLE, and the aborted requester receives no result.
- Only one gnt bit is ever high; gnt and resp_valid are never high in the same cycle for the same operation.

Test Plan:
- Single request, correct inverter: req=4'b0001, data0=8'hA5 held until gnt -> gnt=0001 in cycle 1, inv_in=8'hA5 in cycle 2, resp_valid in cycle 3 with resp_id=0, resp_data=8'h5A, mismatch=0.
- Simultaneous requests from reset: req=4'b1111 (data k=8'h10+k), each requester drops req after its gnt -> grants in order 0,1,2,3. Responses are 8'hEF, 8'hEE, 8'hED, 8'hEC with ids 0..3, one every 3 cycles.
- Round-robin fairness: requester 2 and requester 0 both re-request continuously -> grants alternate 0,2,0,2; requester 2 is never starved.
- Faulty datapath: force inv_out=dreg (pass-through) with data=8'h3C -> resp_data=8'h3C and mismatch=1. mismatch stays 1 across later correct operations until rst.
- Reset mid-op: assert rst for one cycle while state=EXEC -> no resp_valid; gnt=0, busy=0, inv_in=0 next cycle. A following req=4'b0001 is granted to requester 0 (rr_last reset to NREQ-1).
- Idle stability: req=0 for 20 cycles -> gnt=0, resp_valid=0, busy=0 throughout.
